// File: rtl/videomem_wr_req_if.sv
// Bundle of the pixel-in, request and write-data signals of the frame-buffer
// write requester.
//   master : the requester itself. It accepts pixel words, issues burst write
//            requests with an address and hands out burst words.
//   slave  : the surroundings. These are the pixel unpacker and the memory
//            controller write port.
// Signals:
//   frame_start   1-cycle pulse, restart the frame at address 0
//   in_data/in_valid/in_ready   pixel word stream
//   mem_ready     controller can take a request
//   write_request/write_req_ack/write_addr   burst write request handshake
//   wdata_req/wdata   controller pulls one burst word per wdata_req cycle
//   frame_done    1-cycle pulse after the last burst of the frame
interface videomem_wr_req_if;
    logic        frame_start;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_ready;
    logic        write_request;
    logic        write_req_ack;
    logic [24:0] write_addr;
    logic        wdata_req;
    logic [31:0] wdata;
    logic        frame_done;

    modport master (
        input  frame_start, in_data, in_valid, mem_ready, write_req_ack, wdata_req,
        output in_ready, write_request, write_addr, wdata, frame_done
    );

    modport slave (
        output frame_start, in_data, in_valid, mem_ready, write_req_ack, wdata_req,
        input  in_ready, write_request, write_addr, wdata, frame_done
    );
endinterface

// File: rtl/videomem_wr_req.sv
// Frame-buffer write requester.
// The block collects 32-bit pixel words into bursts of BURST_LEN words. For
// each full burst it issues one SDRAM write request at address
// {line, burst_idx, 2'b00}, which is the layout the display read path uses.
// Ports:
//   mem_clock  sole clock
//   reset      synchronous, active-high
//   bus        videomem_wr_req_if.master. It carries the pixel stream, the
//              request handshake, the write data and frame_done.
// Flow:
//   FILL -> REQ -> DATA -> FILL
//   DONE is entered after the last burst of a frame and is held until
//   frame_start.
module videomem_wr_req #(
    parameter int BURST_LEN      = 4,
    parameter int MAX_NUM_HWRITE = 160,
    parameter int LINE_NUM       = 720
) (
    input  logic              mem_clock,
    input  logic              reset,
    videomem_wr_req_if.master bus
);

    localparam int              IDX_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [9:0]      HW_LAST  = 10'(MAX_NUM_HWRITE - 1);
    localparam logic [12:0]     LINE_END = 13'(LINE_NUM);

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [IDX_W-1:0] fill_idx_r;
    logic [IDX_W-1:0] rd_idx_r;
    logic [31:0]      burst_buf_r [BURST_LEN];
    logic [12:0]      num_lines_r;
    logic [9:0]       num_hwrite_r;
    logic             write_request_r;
    logic             frame_done_r;
    logic             pending_restart_r;

    logic             accept_s;
    logic             req_acc_s;
    logic             take_s;
    logic             last_take_s;
    logic             restart_s;
    logic             hw_wrap_s;
    logic             frame_end_s;

    assign bus.in_ready      = (state_r == ST_FILL);
    assign bus.wdata         = burst_buf_r[rd_idx_r];
    assign bus.write_addr    = {num_lines_r, num_hwrite_r, 2'b00};
    assign bus.write_request = write_request_r;
    assign bus.frame_done    = frame_done_r;

    // Handshake decodes and next-state selection.
    always_comb begin
        accept_s     = 1'b0;
        req_acc_s    = 1'b0;
        take_s       = 1'b0;
        last_take_s  = 1'b0;
        restart_s    = 1'b0;
        hw_wrap_s    = 1'b0;
        frame_end_s  = 1'b0;
        next_state_s = state_r;

        // frame_start wins over a same-cycle word or ack.
        accept_s    = (state_r == ST_FILL) && bus.in_valid && !bus.frame_start;
        req_acc_s   = (state_r == ST_REQ) && write_request_r && bus.write_req_ack
                      && !bus.frame_start;
        take_s      = (state_r == ST_DATA) && bus.wdata_req;
        last_take_s = take_s && (rd_idx_r == LAST_IDX);
        restart_s   = pending_restart_r || bus.frame_start;
        hw_wrap_s   = (num_hwrite_r == HW_LAST);
        frame_end_s = hw_wrap_s && ((num_lines_r + 13'd1) == LINE_END);

        case (state_r)
            ST_FILL: begin
                if (accept_s && (fill_idx_r == LAST_IDX)) begin
                    next_state_s = ST_REQ;
                end else begin
                    next_state_s = ST_FILL;
                end
            end
            ST_REQ: begin
                if (bus.frame_start) begin
                    next_state_s = ST_FILL;
                end else if (req_acc_s) begin
                    next_state_s = ST_DATA;
                end else begin
                    next_state_s = ST_REQ;
                end
            end
            ST_DATA: begin
                if (last_take_s && !restart_s && frame_end_s) begin
                    next_state_s = ST_DONE;
                end else if (last_take_s) begin
                    next_state_s = ST_FILL;
                end else begin
                    next_state_s = ST_DATA;
                end
            end
            ST_DONE: begin
                if (bus.frame_start) begin
                    next_state_s = ST_FILL;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: begin
                next_state_s = ST_FILL;
            end
        endcase
    end

    // State register.
    always_ff @(posedge mem_clock) begin
        if (reset) begin
            state_r <= ST_FILL;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Indices, address counters, request and frame_done registers.
    always_ff @(posedge mem_clock) begin
        if (reset) begin
            fill_idx_r        <= '0;
            rd_idx_r          <= '0;
            num_lines_r       <= 13'd0;
            num_hwrite_r      <= 10'd0;
            write_request_r   <= 1'b0;
            frame_done_r      <= 1'b0;
            pending_restart_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            case (state_r)
                ST_FILL: begin
                    write_request_r <= 1'b0;
                    if (bus.frame_start) begin
                        fill_idx_r   <= '0;
                        num_lines_r  <= 13'd0;
                        num_hwrite_r <= 10'd0;
                    end else if (accept_s) begin
                        fill_idx_r <= fill_idx_r + IDX_ONE;
                    end
                end
                ST_REQ: begin
                    if (bus.frame_start) begin
                        write_request_r <= 1'b0;
                        fill_idx_r      <= '0;
                        num_lines_r     <= 13'd0;
                        num_hwrite_r    <= 10'd0;
                    end else if (req_acc_s) begin
                        write_request_r <= 1'b0;
                    end else begin
                        // Request follows mem_ready one cycle late.
                        write_request_r <= bus.mem_ready;
                    end
                end
                ST_DATA: begin
                    write_request_r <= 1'b0;
                    // The burst is already committed, so a restart waits for it.
                    if (bus.frame_start) begin
                        pending_restart_r <= 1'b1;
                    end
                    if (take_s) begin
                        rd_idx_r <= rd_idx_r + IDX_ONE;
                    end
                    if (last_take_s) begin
                        rd_idx_r          <= '0;
                        fill_idx_r        <= '0;
                        pending_restart_r <= 1'b0;
                        if (restart_s) begin
                            num_lines_r  <= 13'd0;
                            num_hwrite_r <= 10'd0;
                        end else if (hw_wrap_s) begin
                            num_hwrite_r <= 10'd0;
                            num_lines_r  <= num_lines_r + 13'd1;
                        end else begin
                            num_hwrite_r <= num_hwrite_r + 10'd1;
                        end
                        if (frame_end_s && !restart_s) begin
                            frame_done_r <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    write_request_r <= 1'b0;
                    if (bus.frame_start) begin
                        num_lines_r  <= 13'd0;
                        num_hwrite_r <= 10'd0;
                    end
                end
                default: begin
                    write_request_r <= 1'b0;
                end
            endcase
        end
    end

    // Burst word storage. The storage needs no reset because fill_idx restarts
    // at 0 on reset.
    always_ff @(posedge mem_clock) begin
        if (!reset && accept_s) begin
            burst_buf_r[fill_idx_r] <= bus.in_data;
        end
    end

endmodule

// File: tb/tb_videomem_wr_req.sv
module tb_videomem_wr_req;

    localparam int MAX_HW = 160;
    localparam int LINES  = 3;
    localparam int FRAME  = MAX_HW * LINES;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   burst_cnt;
    logic [31:0] exp_q [$];

    videomem_wr_req_if vif ();

    videomem_wr_req #(
        .BURST_LEN      (4),
        .MAX_NUM_HWRITE (MAX_HW),
        .LINE_NUM       (LINES)
    ) dut (
        .mem_clock (clk),
        .reset     (rst),
        .bus       (vif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference address: burst n of the frame sits at line n/MAX, slot n%MAX.
    function automatic logic [31:0] exp_addr(input int n);
        int line;
        int hw;
        line = n / MAX_HW;
        hw   = n % MAX_HW;
        return 32'(line * 4096 + hw * 4);
    endfunction

    task automatic push_word(input logic [31:0] d, input int gmax);
        int n;
        n = 0;
        repeat ($urandom_range(0, gmax)) tick();
        while (vif.in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("in_ready_wait", {31'd0, vif.in_ready}, 32'd1);
        vif.in_valid = 1'b1;
        vif.in_data  = d;
        tick();
        vif.in_valid = 1'b0;
        exp_q.push_back(d);
    endtask

    task automatic pulse_frame_start();
        vif.frame_start = 1'b1;
        tick();
        vif.frame_start = 1'b0;
        exp_q.delete();
        burst_cnt = 0;
    endtask

    // mode 0: immediate mem_ready/ack, 1: random ack delay, 2: 10-cycle mem_ready stall
    task automatic send_burst(input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3,
                              input int mode, input bit restart, input int gmax);
        int n;
        logic [31:0] ew;
        push_word(w0, gmax);
        push_word(w1, gmax);
        push_word(w2, gmax);
        push_word(w3, gmax);
        chk("in_ready_req", {31'd0, vif.in_ready}, 32'd0);
        if (mode == 0) begin
            vif.mem_ready     = 1'b1;
            vif.write_req_ack = 1'b1;
            chk("req_lag_low", {31'd0, vif.write_request}, 32'd0);
            tick();
            chk("req_rise", {31'd0, vif.write_request}, 32'd1);
        end else if (mode == 2) begin
            vif.mem_ready     = 1'b0;
            vif.write_req_ack = 1'b1;
            for (int i = 0; i < 10; i++) begin
                tick();
                chk("stall_no_req", {31'd0, vif.write_request}, 32'd0);
                chk("stall_addr", {7'd0, vif.write_addr}, exp_addr(burst_cnt));
            end
            vif.mem_ready = 1'b1;
            tick();
            chk("stall_req_rise", {31'd0, vif.write_request}, 32'd1);
        end else begin
            vif.mem_ready = 1'b1;
            n = 0;
            while (!(vif.write_request === 1'b1 && vif.write_req_ack === 1'b1) && n < 100) begin
                tick();
                vif.write_req_ack = 1'($urandom_range(0, 1));
                n++;
            end
            chk("req_timeout", {31'd0, (n < 100)}, 32'd1);
        end
        chk("req_addr", {7'd0, vif.write_addr}, exp_addr(burst_cnt));
        tick();
        vif.write_req_ack = 1'b0;
        vif.mem_ready     = 1'b0;
        chk("req_drop", {31'd0, vif.write_request}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, gmax)) tick();
            vif.wdata_req = 1'b1;
            if (restart && i == 1) vif.frame_start = 1'b1;
            if (i == 3) chk("addr_stable", {7'd0, vif.write_addr}, exp_addr(burst_cnt));
            ew = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            chk("wdata", vif.wdata, ew);
            tick();
            vif.wdata_req   = 1'b0;
            vif.frame_start = 1'b0;
        end
        if (restart) burst_cnt = 0;
        else burst_cnt++;
        chk("frame_done", {31'd0, vif.frame_done}, {31'd0, (!restart && burst_cnt == FRAME)});
        chk("next_addr", {7'd0, vif.write_addr}, exp_addr(burst_cnt));
        chk("in_ready_after", {31'd0, vif.in_ready}, {31'd0, !(!restart && burst_cnt == FRAME)});
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        burst_cnt         = 0;
        rst               = 1'b1;
        vif.frame_start   = 1'b0;
        vif.in_data       = 32'd0;
        vif.in_valid      = 1'b0;
        vif.mem_ready     = 1'b0;
        vif.write_req_ack = 1'b0;
        vif.wdata_req     = 1'b0;

        // Reset values
        repeat (3) tick();
        chk("rst_req", {31'd0, vif.write_request}, 32'd0);
        chk("rst_in_ready", {31'd0, vif.in_ready}, 32'd1);
        chk("rst_addr", {7'd0, vif.write_addr}, 32'd0);
        chk("rst_frame_done", {31'd0, vif.frame_done}, 32'd0);
        rst = 1'b0;

        // First burst with fixed data
        send_burst(32'h11, 32'h22, 32'h33, 32'h44, 0, 1'b0, 0);
        chk("addr_after_first", {7'd0, vif.write_addr}, 32'h0000_0004);

        // Complete the first line
        while (burst_cnt < MAX_HW)
            send_burst($urandom, $urandom, $urandom, $urandom, 1, 1'b0, 1);
        chk("line1_addr", {7'd0, vif.write_addr}, 32'h0000_1000);

        // mem_ready held low with ack high
        send_burst($urandom, $urandom, $urandom, $urandom, 2, 1'b0, 0);

        // Run to end of frame
        while (burst_cnt < FRAME)
            send_burst($urandom, $urandom, $urandom, $urandom, 1, 1'b0, 1);
        tick();
        chk("done_pulse_end", {31'd0, vif.frame_done}, 32'd0);
        chk("done_in_ready", {31'd0, vif.in_ready}, 32'd0);
        pulse_frame_start();
        chk("restart_addr", {7'd0, vif.write_addr}, 32'd0);
        chk("restart_in_ready", {31'd0, vif.in_ready}, 32'd1);

        // Partial buffer discarded by frame_start
        push_word(32'h0000_00B0, 0);
        push_word(32'h0000_00B1, 0);
        pulse_frame_start();
        send_burst(32'hA0, 32'hA1, 32'hA2, 32'hA3, 0, 1'b0, 0);
        // frame_start during DATA: burst finishes, next burst restarts at 0
        send_burst($urandom, $urandom, $urandom, $urandom, 1, 1'b1, 1);
        send_burst($urandom, $urandom, $urandom, $urandom, 1, 1'b0, 1);

        // Reset mid-fill drops the partial buffer
        push_word(32'h0000_00C0, 0);
        push_word(32'h0000_00C1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        burst_cnt = 0;
        chk("midrst_in_ready", {31'd0, vif.in_ready}, 32'd1);
        chk("midrst_addr", {7'd0, vif.write_addr}, 32'd0);
        chk("midrst_req", {31'd0, vif.write_request}, 32'd0);
        send_burst($urandom, $urandom, $urandom, $urandom, 1, 1'b0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
